// File: rtl/bist_controller.sv
// Two-phase BIST driver for a fault-injectable cut: record the fault-free response, then
// replay every pattern under each (site, stuck value) fault and flag any deviation.
module bist_controller #(
    parameter int N_IN    = 3,
    parameter int N_SITES = 12,
    localparam int NP = 2**N_IN,
    localparam int NF = 2*N_SITES,
    localparam int CW = $clog2(NF+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [N_IN-1:0]    cut_a,
    output logic [N_SITES-1:0] cut_check,
    output logic               cut_value,
    input  logic               cut_y,
    output logic               busy,
    output logic               done,
    output logic [NP-1:0]      golden,
    output logic [NF-1:0]      detected,
    output logic [CW-1:0]      fault_cnt
);

    localparam int FW = $clog2(NF);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GOLDEN = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state;
    logic [FW-1:0] f;
    logic [FW-1:0] f_nxt;

    assign f_nxt = f + FW'(1);

    // cut_a doubles as the pattern counter; cut_check/cut_value follow the fault index f.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            f         <= '0;
            cut_a     <= '0;
            cut_check <= '0;
            cut_value <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            golden    <= '0;
            detected  <= '0;
            fault_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_GOLDEN;
                        f         <= '0;
                        cut_a     <= '0;
                        cut_check <= '0;
                        cut_value <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        golden    <= '0;
                        detected  <= '0;
                        fault_cnt <= '0;
                    end
                end
                ST_GOLDEN: begin
                    golden[cut_a] <= cut_y;
                    cut_a         <= cut_a + N_IN'(1);
                    if (&cut_a) begin
                        state     <= ST_FAULT;
                        f         <= '0;
                        cut_check <= N_SITES'(1);
                        cut_value <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if ((cut_y != golden[cut_a]) && !detected[f]) begin
                        detected[f] <= 1'b1;
                        fault_cnt   <= fault_cnt + CW'(1);
                    end
                    cut_a <= cut_a + N_IN'(1);
                    if (&cut_a) begin
                        // Last pattern of the last fault ends the run; a start here is dropped.
                        if (f == FW'(NF-1)) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cut_check <= '0;
                            cut_value <= 1'b0;
                        end else begin
                            f         <= f_nxt;
                            cut_check <= N_SITES'(1) << f_nxt[FW-1:1];
                            cut_value <= f_nxt[0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: behavioural cut models, a run-level reference model,
// a per-cycle compare process and directed plus randomized runs.
module tb_bist_controller;

    localparam int N_IN    = 3;
    localparam int N_SITES = 12;
    localparam int NP      = 8;
    localparam int NF      = 24;
    localparam int RUN_LEN = (NF + 1) * NP;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [N_IN-1:0]    cut_a;
    logic [N_SITES-1:0] cut_check;
    logic               cut_value;
    logic               cut_y;
    logic               busy;
    logic               done;
    logic [NP-1:0]      golden;
    logic [NF-1:0]      detected;
    logic [4:0]         fault_cnt;

    int total = 0;
    int bad   = 0;

    // cut_mode 0: gate netlist y=a1&a2, 1: y tied 0, 2: random response tables
    int        cut_mode = 0;
    logic [7:0] r_good;
    logic [7:0] r_flt [NF];

    always #5 clk = ~clk;

    bist_controller #(.N_IN(N_IN), .N_SITES(N_SITES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cut_a(cut_a), .cut_check(cut_check), .cut_value(cut_value), .cut_y(cut_y),
        .busy(busy), .done(done), .golden(golden), .detected(detected), .fault_cnt(fault_cnt)
    );

    function automatic logic sa(input logic x, input logic [11:0] chk, input logic v, input int i);
        return chk[i] ? v : x;
    endfunction

    // Sites 0,3,4,5,8 are dead logic; site 10 is a redundant branch of the AND output.
    function automatic logic net_fn(input logic [2:0] a, input logic [11:0] chk, input logic v);
        logic [11:0] n;
        n[0]  = sa(a[0], chk, v, 0);
        n[1]  = sa(a[1], chk, v, 1);
        n[2]  = sa(a[2], chk, v, 2);
        n[3]  = sa(n[0], chk, v, 3);
        n[4]  = sa(~n[3], chk, v, 4);
        n[5]  = sa(n[3] & n[4], chk, v, 5);
        n[6]  = sa(n[1], chk, v, 6);
        n[7]  = sa(n[2], chk, v, 7);
        n[8]  = sa(n[5], chk, v, 8);
        n[9]  = sa(n[6] & n[7], chk, v, 9);
        n[10] = sa(n[9], chk, v, 10);
        n[11] = sa(n[9] & n[10], chk, v, 11);
        return n[11];
    endfunction

    function automatic logic cut_fn(input logic [2:0] a, input logic [11:0] chk, input logic v);
        int site;
        logic [7:0] row;
        if (cut_mode == 0) return net_fn(a, chk, v);
        if (cut_mode == 1) return 1'b0;
        if (chk == 12'd0) return r_good[a];
        site = 0;
        for (int i = N_SITES - 1; i >= 0; i--) if (chk[i]) site = i;
        row = r_flt[2*site + int'(v)];
        return row[a];
    endfunction

    always_comb cut_y = cut_fn(cut_a, cut_check, cut_value);

    // ---------------- reference model ----------------
    bit         m_seen = 0;
    bit         m_busy = 0;
    bit         m_done = 0;
    int         m_k = 0;
    logic [7:0] m_gold = '0;
    logic [23:0] m_det = '0;
    int         m_cnt = 0;

    task automatic model_final();
        m_gold = '0;
        m_det  = '0;
        for (int p = 0; p < NP; p++) m_gold[p] = cut_fn(3'(p), 12'd0, 1'b0);
        for (int f = 0; f < NF; f++)
            for (int p = 0; p < NP; p++)
                if (cut_fn(3'(p), 12'(1) << (f / 2), 1'(f % 2)) != m_gold[p]) m_det[f] = 1'b1;
        m_cnt = $countones(m_det);
    endtask

    always @(posedge clk) begin
        m_seen = 1;
        if (rst) begin
            m_busy = 0; m_done = 0; m_k = 0; m_gold = '0; m_det = '0; m_cnt = 0;
        end else if (!m_busy && start) begin
            m_busy = 1; m_done = 0; m_k = 0; m_gold = '0; m_det = '0; m_cnt = 0;
        end else if (m_busy) begin
            m_k++;
            if (m_k == RUN_LEN) begin
                m_busy = 0;
                m_done = 1;
                model_final();
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: drive outputs always, results only when idle or done.
    always @(negedge clk) begin
        if (m_seen) begin
            int w;
            logic [2:0]  e_a;
            logic [11:0] e_chk;
            logic        e_v;
            e_a = '0; e_chk = '0; e_v = 1'b0;
            if (m_busy) begin
                w   = m_k / NP;
                e_a = 3'(m_k % NP);
                if (w > 0) begin
                    e_chk = 12'(1) << ((w - 1) / 2);
                    e_v   = 1'((w - 1) % 2);
                end
            end
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("cut_a", 64'(cut_a), 64'(e_a));
            chk("cut_check", 64'(cut_check), 64'(e_chk));
            chk("cut_value", 64'(cut_value), 64'(e_v));
            if (!m_busy) begin
                chk("golden", 64'(golden), 64'(m_gold));
                chk("detected", 64'(detected), 64'(m_det));
                chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Watches a run; optional start pulses at busy cycles p1/p2; returns early at stop_at.
    task automatic watch_run(input int p1, input int p2, input int stop_at,
                             output int bcyc, output int wraps);
        bit finished;
        bcyc = 0; wraps = 0; finished = 0;
        for (int i = 0; i < 2 * RUN_LEN; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin finished = 1; break; end
            if (busy) begin
                if (cut_a == 3'd7) wraps++;
                if (bcyc == 100 && cut_check != 12'd0) begin end
                bcyc++;
            end
            if (bcyc == stop_at) begin finished = 1; break; end
            if (bcyc == p1 || bcyc == p2) start = 1'b1;
        end
        start = 1'b0;
        if (!finished) chk("run_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_default_results(input string tag);
        chk({tag, "_golden"}, 64'(golden), 64'h00C0);
        chk({tag, "_detected"}, 64'(detected), 64'hDCF03C);
        chk({tag, "_fault_cnt"}, 64'(fault_cnt), 64'd13);
    endtask

    // Captures cut drive during fault window 7 (site 3, stuck-at-1).
    logic [11:0] win7_chk;
    logic        win7_v;
    always @(negedge clk) if (m_busy && m_k == 8 * 8 + 3) begin
        win7_chk = cut_check;
        win7_v   = cut_value;
    end

    initial begin
        int bc, wr;
        // reset with start asserted
        rst = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_detected", 64'(detected), 64'd0);

        // default cut run
        cut_mode = 0;
        pulse_start();
        watch_run(-1, -1, -1, bc, wr);
        chk("t2_busy_cycles", 64'(bc), 64'(RUN_LEN));
        chk("t3_wraps", 64'(wr), 64'd25);
        chk("t3_win7_check", 64'(win7_chk), 64'h008);
        chk("t3_win7_value", 64'(win7_v), 64'd1);
        chk("t2_done", 64'(done), 64'd1);
        check_default_results("t2");
        repeat (3) @(negedge clk);
        chk("t2_done_held", 64'(done), 64'd1);

        // y tied 0
        cut_mode = 1;
        pulse_start();
        watch_run(-1, -1, -1, bc, wr);
        chk("t4_busy_cycles", 64'(bc), 64'(RUN_LEN));
        chk("t4_golden", 64'(golden), 64'd0);
        chk("t4_detected", 64'(detected), 64'd0);
        chk("t4_fault_cnt", 64'(fault_cnt), 64'd0);

        // start ignored while busy
        cut_mode = 0;
        pulse_start();
        watch_run(1, 100, -1, bc, wr);
        chk("t5_busy_cycles", 64'(bc), 64'(RUN_LEN));
        check_default_results("t5");

        // reset mid-run, then fresh run
        pulse_start();
        watch_run(-1, -1, 120, bc, wr);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst_detected", 64'(detected), 64'd0);
        pulse_start();
        watch_run(-1, -1, -1, bc, wr);
        chk("t6_busy_cycles", 64'(bc), 64'(RUN_LEN));
        check_default_results("t6");

        // randomized cuts, gaps and ignored start pulses
        for (int r = 0; r < 8; r++) begin
            r_good = 8'($urandom);
            for (int i = 0; i < NF; i++)
                r_flt[i] = r_good ^ 8'($urandom & $urandom & $urandom);
            cut_mode = 2;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse_start();
            watch_run($urandom_range(1, RUN_LEN - 1), $urandom_range(1, RUN_LEN), -1, bc, wr);
            chk("rand_busy_cycles", 64'(bc), 64'(RUN_LEN));
        end
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
